// File: rtl/demux1to3_buf_pkg.sv
// Shared definitions for the 1-to-3 registered demultiplexer.
// Holds the select encodings and the channel count used by the top level.
package demux1to3_buf_pkg;

    localparam int NUM_CH = 3;
    localparam int SEL_W  = 2;

    localparam logic [SEL_W-1:0] SEL_CH0 = 2'd0;
    localparam logic [SEL_W-1:0] SEL_CH1 = 2'd1;
    localparam logic [SEL_W-1:0] SEL_CH2 = 2'd2;
    localparam logic [SEL_W-1:0] SEL_BAD = 2'd3;

    function automatic logic sel_legal(input logic [SEL_W-1:0] sel);
        return (sel != SEL_BAD);
    endfunction

endpackage

// File: rtl/demux1to3_buf_if.sv
// Handshake bundle for demux1to3_buf: one input channel, three output channels,
// plus the illegal-select error pulse and drop counter.
interface demux1to3_buf_if #(
    parameter int size  = 32,
    parameter int CNT_W = 8
);
    import demux1to3_buf_pkg::*;

    logic [size-1:0]  data_i;
    logic [SEL_W-1:0] select_i;
    logic             valid_i;
    logic             ready_o;

    logic [size-1:0]  data0_o;
    logic [size-1:0]  data1_o;
    logic [size-1:0]  data2_o;
    logic             valid0_o;
    logic             valid1_o;
    logic             valid2_o;
    logic             ready0_i;
    logic             ready1_i;
    logic             ready2_i;

    logic             err_o;
    logic [CNT_W-1:0] drop_cnt_o;

    // Producer plus the three consumers, as seen from outside the block.
    modport master (
        output data_i, select_i, valid_i,
        input  ready_o,
        input  data0_o, data1_o, data2_o,
        input  valid0_o, valid1_o, valid2_o,
        output ready0_i, ready1_i, ready2_i,
        input  err_o, drop_cnt_o
    );

    modport slave (
        input  data_i, select_i, valid_i,
        output ready_o,
        output data0_o, data1_o, data2_o,
        output valid0_o, valid1_o, valid2_o,
        input  ready0_i, ready1_i, ready2_i,
        output err_o, drop_cnt_o
    );

endinterface

// File: rtl/demux1to3_buf_slot.sv
// One-entry holding register for a single output channel. A slot that drains
// in a cycle may be reloaded in that same cycle.
module demux_slot #(
    parameter int size = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic [size-1:0] data_i,
    input  logic            ready_i,
    output logic            valid_o,
    output logic [size-1:0] data_o,
    output logic            can_accept_o
);

    logic            full_reg;
    logic [size-1:0] data_reg;

    assign can_accept_o = !full_reg || ready_i;
    assign valid_o      = full_reg;
    assign data_o       = data_reg;

    // A load wins over a drain so the slot stays full with the new word.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            full_reg <= 1'b0;
            data_reg <= '0;
        end else if (load_i) begin
            full_reg <= 1'b1;
            data_reg <= data_i;
        end else if (full_reg && ready_i) begin
            full_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/demux1to3_buf.sv
// Registered 1-to-3 demultiplexer: steers each accepted word into one of three
// holding slots; illegal-select words are dropped, flagged and counted.
module demux1to3_buf
    import demux1to3_buf_pkg::*;
#(
    parameter int size  = 32,
    parameter int CNT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    demux1to3_buf_if.slave       bus
);

    logic [NUM_CH-1:0] slot_ready;
    logic [NUM_CH-1:0] slot_valid;
    logic [NUM_CH-1:0] slot_can_accept;
    logic [NUM_CH-1:0] slot_load;
    logic [size-1:0]   slot_data [NUM_CH];

    logic              ready_next;
    logic              accept;
    logic              drop;
    logic              err_reg;
    logic [CNT_W-1:0]  cnt_reg;

    assign slot_ready = {bus.ready2_i, bus.ready1_i, bus.ready0_i};

    // Illegal selects are always accepted so a bad word never stalls upstream.
    always_comb begin
        ready_next = 1'b1;
        case (bus.select_i)
            SEL_CH0: ready_next = slot_can_accept[0];
            SEL_CH1: ready_next = slot_can_accept[1];
            SEL_CH2: ready_next = slot_can_accept[2];
            default: ready_next = 1'b1;
        endcase
    end

    assign bus.ready_o = ready_next;
    assign accept      = bus.valid_i && ready_next;
    assign drop        = accept && !sel_legal(bus.select_i);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
            assign slot_load[gi] = accept && (bus.select_i == SEL_W'(gi));

            demux_slot #(
                .size (size)
            ) u_slot (
                .clk_i        (clk_i),
                .rst_i        (rst_i),
                .load_i       (slot_load[gi]),
                .data_i       (bus.data_i),
                .ready_i      (slot_ready[gi]),
                .valid_o      (slot_valid[gi]),
                .data_o       (slot_data[gi]),
                .can_accept_o (slot_can_accept[gi])
            );
        end
    endgenerate

    assign bus.valid0_o = slot_valid[0];
    assign bus.valid1_o = slot_valid[1];
    assign bus.valid2_o = slot_valid[2];
    assign bus.data0_o  = slot_data[0];
    assign bus.data1_o  = slot_data[1];
    assign bus.data2_o  = slot_data[2];

    // Drop counter saturates at all-ones instead of wrapping.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_reg <= 1'b0;
            cnt_reg <= '0;
        end else begin
            err_reg <= drop;
            if (drop && (cnt_reg != {CNT_W{1'b1}})) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign bus.err_o      = err_reg;
    assign bus.drop_cnt_o = cnt_reg;

endmodule
